// File: rtl/controle_bateria.sv
// controle_bateria
// Battery model and controller for the vacuum robot. A discrete charge level
// drains while the robot moves and refills while it is docked. The block drives
// the battery LED bar, which blinks when the charge is low, enables the motors
// and requests a return to the base.
//
// Ports
//   clk              in   system clock, rising edge
//   rst_n            in   synchronous reset, active low
//   ligar            in   power switch (1 = robot on)
//   em_movimento     in   motors commanded to move (drains the battery)
//   carregando       in   robot docked on the charger
//   nivel            out  current charge level, 0..NIVEL_MAX
//   leds             out  LED bar: thermometer of nivel, with blink behaviour
//   bateria_baixa    out  nivel <= LIMIAR_BAIXO
//   retornar_base    out  OPERANDO and battery low
//   motor_habilitado out  1 only in OPERANDO
//   carga_completa   out  CARREGANDO and nivel == NIVEL_MAX
//   o_estado         out  debug view of the FSM state
//                         (0 DESLIGADO, 1 OPERANDO, 2 CARREGANDO, 3 VAZIO)
//
// Handshake: this block has no valid/ready interfaces. The inputs are level
// signals, sampled on every rising edge of clk.
module controle_bateria #(
    parameter int DIV_TICK        = 50000,
    parameter int CICLOS_DESCARGA = 1000,
    parameter int CICLOS_CARGA    = 500,
    parameter int NIVEL_MAX       = 9,
    parameter int LIMIAR_BAIXO    = 2,
    parameter int PISCA_TICKS     = 250
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ligar,
    input  logic                 em_movimento,
    input  logic                 carregando,
    output logic [3:0]           nivel,
    output logic [NIVEL_MAX-1:0] leds,
    output logic                 bateria_baixa,
    output logic                 retornar_base,
    output logic                 motor_habilitado,
    output logic                 carga_completa,
    output logic [1:0]           o_estado
);

    // The level is a 4-bit value, so the LED bar can have at most 15 LEDs.
    if (NIVEL_MAX < 1 || NIVEL_MAX > 15) begin : g_chk_nivel
        $error("controle_bateria: NIVEL_MAX must be in 1..15");
    end

    localparam int ACC_MAX = (CICLOS_DESCARGA > CICLOS_CARGA) ? CICLOS_DESCARGA : CICLOS_CARGA;
    localparam int PW      = $clog2(DIV_TICK + 1);
    localparam int AW      = $clog2(ACC_MAX + 1);
    localparam int BW      = $clog2(PISCA_TICKS + 1);

    localparam logic [PW-1:0] PRESC_FIM   = PW'(DIV_TICK - 1);
    localparam logic [AW-1:0] DESCARGA_FIM = AW'(CICLOS_DESCARGA - 1);
    localparam logic [AW-1:0] CARGA_FIM    = AW'(CICLOS_CARGA - 1);
    localparam logic [BW-1:0] PISCA_FIM    = BW'(PISCA_TICKS - 1);
    localparam logic [3:0]    NMAX         = 4'(NIVEL_MAX);
    localparam logic [3:0]    LIMIAR       = 4'(LIMIAR_BAIXO);

    typedef enum logic [1:0] {
        DESLIGADO  = 2'd0,
        OPERANDO   = 2'd1,
        CARREGANDO = 2'd2,
        VAZIO      = 2'd3
    } estado_t;

    estado_t              r_estado;
    logic [3:0]           r_nivel;
    logic [PW-1:0]        r_presc;
    logic [AW-1:0]        r_acc;
    logic [BW-1:0]        r_pisca_cnt;
    logic                 r_pisca;
    logic [NIVEL_MAX-1:0] r_leds;
    logic                 r_baixa;
    logic                 r_retornar;
    logic                 r_motor;
    logic                 r_completa;

    estado_t              w_proximo;
    logic                 w_tick;
    logic                 w_baixa;
    logic [NIVEL_MAX-1:0] w_termometro;
    logic [NIVEL_MAX-1:0] w_leds;

    assign w_tick  = (r_presc == PRESC_FIM);
    assign w_baixa = (r_nivel <= LIMIAR);

    // Next state. The charger always wins.
    always_comb begin
        w_proximo = r_estado;
        case (r_estado)
            DESLIGADO: begin
                if (carregando)                 w_proximo = CARREGANDO;
                else if (ligar && r_nivel != 0) w_proximo = OPERANDO;
                else if (ligar)                 w_proximo = VAZIO;
            end
            OPERANDO: begin
                if (carregando)        w_proximo = CARREGANDO;
                else if (!ligar)       w_proximo = DESLIGADO;
                else if (r_nivel == 0) w_proximo = VAZIO;
            end
            CARREGANDO: begin
                if (!carregando) begin
                    if (ligar && r_nivel != 0) w_proximo = OPERANDO;
                    else if (ligar)            w_proximo = VAZIO;
                    else                       w_proximo = DESLIGADO;
                end
            end
            VAZIO: begin
                if (carregando)  w_proximo = CARREGANDO;
                else if (!ligar) w_proximo = DESLIGADO;
            end
            default: w_proximo = DESLIGADO;
        endcase
    end

    // LED bar contents for the next output register.
    always_comb begin
        w_termometro = '0;
        for (int i = 0; i < NIVEL_MAX; i++) begin
            w_termometro[i] = (4'(i) < r_nivel);
        end
        w_leds = '0;
        case (r_estado)
            OPERANDO:   w_leds = w_baixa ? (w_termometro & {NIVEL_MAX{r_pisca}}) : w_termometro;
            CARREGANDO: w_leds = w_termometro;
            VAZIO:      w_leds[0] = r_pisca;
            default:    w_leds = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_estado    <= DESLIGADO;
            r_nivel     <= NMAX;
            r_presc     <= '0;
            r_acc       <= '0;
            r_pisca_cnt <= '0;
            r_pisca     <= 1'b0;
        end else begin
            r_estado <= w_proximo;
            r_presc  <= w_tick ? '0 : r_presc + 1'b1;

            // The blink runs freely from the base tick, whatever the state.
            if (w_tick) begin
                if (r_pisca_cnt == PISCA_FIM) begin
                    r_pisca_cnt <= '0;
                    r_pisca     <= ~r_pisca;
                end else begin
                    r_pisca_cnt <= r_pisca_cnt + 1'b1;
                end
            end

            if (w_tick && r_estado == OPERANDO && em_movimento) begin
                if (r_acc == DESCARGA_FIM) begin
                    r_acc <= '0;
                    if (r_nivel != 0) r_nivel <= r_nivel - 1'b1;
                end else begin
                    r_acc <= r_acc + 1'b1;
                end
            end else if (w_tick && r_estado == CARREGANDO) begin
                // A full battery holds the accumulator at 0, so charging
                // neither wraps nor banks progress.
                if (r_nivel == NMAX) begin
                    r_acc <= '0;
                end else if (r_acc == CARGA_FIM) begin
                    r_acc   <= '0;
                    r_nivel <= r_nivel + 1'b1;
                end else begin
                    r_acc <= r_acc + 1'b1;
                end
            end

            // A change of state always restarts the accumulator. This
            // assignment overrides any accumulator update made above.
            if (w_proximo != r_estado) r_acc <= '0;
        end
    end

    // Registered outputs, one clock behind estado/nivel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_leds     <= '0;
            r_baixa    <= 1'b0;
            r_retornar <= 1'b0;
            r_motor    <= 1'b0;
            r_completa <= 1'b0;
        end else begin
            r_leds     <= w_leds;
            r_baixa    <= w_baixa;
            r_retornar <= (r_estado == OPERANDO) && w_baixa;
            r_motor    <= (r_estado == OPERANDO);
            r_completa <= (r_estado == CARREGANDO) && (r_nivel == NMAX);
        end
    end

    assign nivel            = r_nivel;
    assign leds             = r_leds;
    assign bateria_baixa    = r_baixa;
    assign retornar_base    = r_retornar;
    assign motor_habilitado = r_motor;
    assign carga_completa   = r_completa;
    assign o_estado         = r_estado;

endmodule

// File: tb/tb_controle_bateria.sv
module tb_controle_bateria;

    localparam int DIV  = 4;
    localparam int DESC = 3;
    localparam int CARG = 2;
    localparam int NMAX = 9;
    localparam int LIM  = 2;
    localparam int PISC = 2;

    // Reference state numbering, taken from the debug output's documented meaning.
    localparam int S_OFF = 0;
    localparam int S_OP  = 1;
    localparam int S_CHG = 2;
    localparam int S_VAZ = 3;

    logic            clk;
    logic            rst_n;
    logic            ligar;
    logic            em_movimento;
    logic            carregando;
    logic [3:0]      nivel;
    logic [NMAX-1:0] leds;
    logic            bateria_baixa;
    logic            retornar_base;
    logic            motor_habilitado;
    logic            carga_completa;
    logic [1:0]      o_estado;

    controle_bateria #(
        .DIV_TICK(DIV), .CICLOS_DESCARGA(DESC), .CICLOS_CARGA(CARG),
        .NIVEL_MAX(NMAX), .LIMIAR_BAIXO(LIM), .PISCA_TICKS(PISC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ligar(ligar), .em_movimento(em_movimento),
        .carregando(carregando), .nivel(nivel), .leds(leds),
        .bateria_baixa(bateria_baixa), .retornar_base(retornar_base),
        .motor_habilitado(motor_habilitado), .carga_completa(carga_completa),
        .o_estado(o_estado)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model, written directly from the battery rules.
    int m_st, m_lvl, m_cyc, m_ticks_mov, m_ticks_chg, m_blink, m_blink_ticks;
    logic [NMAX-1:0] e_leds;
    logic e_baixa, e_ret, e_motor, e_carga;

    task automatic model_edge();
        int  nst;
        bit  tick;
        bit  low;
        logic [NMAX-1:0] therm;
        if (!rst_n) begin
            m_st = S_OFF; m_lvl = NMAX; m_cyc = 0; m_ticks_mov = 0; m_ticks_chg = 0;
            m_blink = 0; m_blink_ticks = 0;
            e_leds = '0; e_baixa = 0; e_ret = 0; e_motor = 0; e_carga = 0;
        end else begin
            tick  = (m_cyc == DIV - 1);
            low   = (m_lvl <= LIM);
            therm = NMAX'((1 << m_lvl) - 1);
            // Outputs reflect the state and level held before this edge.
            case (m_st)
                S_OP:    e_leds = low ? (m_blink != 0 ? therm : '0) : therm;
                S_CHG:   e_leds = therm;
                S_VAZ:   e_leds = NMAX'(m_blink);
                default: e_leds = '0;
            endcase
            e_baixa = low;
            e_ret   = (m_st == S_OP) && low;
            e_motor = (m_st == S_OP);
            e_carga = (m_st == S_CHG) && (m_lvl == NMAX);

            nst = m_st;
            if (m_st == S_CHG) begin
                if (!carregando) nst = !ligar ? S_OFF : (m_lvl > 0 ? S_OP : S_VAZ);
            end else if (carregando) begin
                nst = S_CHG;
            end else if (m_st == S_OFF) begin
                if (ligar) nst = (m_lvl > 0) ? S_OP : S_VAZ;
            end else if (!ligar) begin
                nst = S_OFF;
            end else if (m_st == S_OP && m_lvl == 0) begin
                nst = S_VAZ;
            end

            if (tick && m_st == S_OP && em_movimento) begin
                m_ticks_mov++;
                if (m_ticks_mov == DESC) begin
                    m_ticks_mov = 0;
                    if (m_lvl > 0) m_lvl--;
                end
            end
            if (tick && m_st == S_CHG) begin
                if (m_lvl == NMAX) m_ticks_chg = 0;
                else begin
                    m_ticks_chg++;
                    if (m_ticks_chg == CARG) begin
                        m_ticks_chg = 0;
                        m_lvl++;
                    end
                end
            end
            if (nst != m_st) begin
                m_ticks_mov = 0;
                m_ticks_chg = 0;
            end
            m_st = nst;

            m_cyc = (m_cyc + 1) % DIV;
            if (tick) begin
                m_blink_ticks++;
                if (m_blink_ticks == PISC) begin
                    m_blink_ticks = 0;
                    m_blink = 1 - m_blink;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("nivel", 32'(nivel), 32'(m_lvl));
        chk("leds", 32'(leds), 32'(e_leds));
        chk("bateria_baixa", 32'(bateria_baixa), 32'(e_baixa));
        chk("retornar_base", 32'(retornar_base), 32'(e_ret));
        chk("motor_habilitado", 32'(motor_habilitado), 32'(e_motor));
        chk("carga_completa", 32'(carga_completa), 32'(e_carga));
        chk("estado", 32'(o_estado), 32'(m_st));
    endtask

    // Driver: one clock. The model advances at the edge, and the DUT is
    // compared at the following falling edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all();
        end
    endtask

    initial begin
        int budget;
        int lvl_antes;
        rst_n = 1'b0; ligar = 1'b0; em_movimento = 1'b0; carregando = 1'b0;
        m_st = S_OFF; m_lvl = NMAX; m_cyc = 0; m_ticks_mov = 0; m_ticks_chg = 0;
        m_blink = 0; m_blink_ticks = 0;
        e_leds = '0; e_baixa = 0; e_ret = 0; e_motor = 0; e_carga = 0;

        // Reset state
        step(2);
        chk("rst_nivel", 32'(nivel), 32'd9);
        chk("rst_leds", 32'(leds), 32'd0);
        rst_n = 1'b1;

        // Power on, full battery
        ligar = 1'b1;
        step(2);
        chk("on_motor", 32'(motor_habilitado), 32'd1);
        chk("on_leds", 32'(leds), 32'h1FF);

        // Move until the battery is low
        em_movimento = 1'b1;
        step(84);
        chk("mov_nivel2", 32'(nivel), 32'd2);
        chk("mov_baixa", 32'(bateria_baixa), 32'd1);
        chk("mov_retornar", 32'(retornar_base), 32'd1);
        step(12);

        // Keep moving into VAZIO; the level stops at 0
        step(40);
        chk("vazio_nivel", 32'(nivel), 32'd0);
        chk("vazio_motor", 32'(motor_habilitado), 32'd0);
        chk("vazio_estado", 32'(o_estado), 32'd3);
        step(10);

        // Dock and charge to full, with no wrap past the maximum
        carregando = 1'b1;
        step(100);
        chk("carga_nivel", 32'(nivel), 32'd9);
        chk("carga_completa", 32'(carga_completa), 32'd1);
        step(20);
        chk("carga_sat", 32'(nivel), 32'd9);

        // Undock, operate without moving: no discharge
        carregando = 1'b0; em_movimento = 1'b0;
        step(2);
        chk("undock_motor", 32'(motor_habilitado), 32'd1);
        lvl_antes = m_lvl;
        step(40);
        chk("pausa_nivel", 32'(nivel), 32'(lvl_antes));

        // Docking while operating moves the FSM to CARREGANDO
        em_movimento = 1'b1;
        step(30);
        carregando = 1'b1;
        step(1);
        chk("op_para_carga", 32'(o_estado), 32'd2);
        carregando = 1'b0;
        step(2);

        // Drain to 4, charge to 5, then reset mid-charge
        budget = 0;
        while (m_lvl > 4 && budget < 400) begin step(1); budget++; end
        chk("timeout_descarga", 32'(budget < 400), 32'd1);
        em_movimento = 1'b0; carregando = 1'b1;
        budget = 0;
        while (m_lvl < 5 && budget < 400) begin step(1); budget++; end
        chk("timeout_carga", 32'(budget < 400), 32'd1);
        rst_n = 1'b0;
        step(1);
        chk("rst_mid_nivel", 32'(nivel), 32'd9);
        chk("rst_mid_leds", 32'(leds), 32'd0);
        chk("rst_mid_completa", 32'(carga_completa), 32'd0);
        chk("rst_mid_motor", 32'(motor_habilitado), 32'd0);
        chk("rst_mid_estado", 32'(o_estado), 32'd0);
        rst_n = 1'b1; carregando = 1'b0;

        // Randomized phase against the reference model
        ligar = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0)  ligar        = ~ligar;
            if ($urandom_range(0, 7) == 0)   em_movimento = ~em_movimento;
            if ($urandom_range(0, 89) == 0)  carregando   = ~carregando;
            rst_n = ($urandom_range(0, 499) != 0);
            step(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
